ram_memory_latency: RTL and testbench



---
 rtl/ram_latency_pkg.sv | 26 ++
 rtl/ram_memory_latency_lfsr_stall_gen.sv | 29 ++
 rtl/ram_memory_latency.sv | 147 ++++++++++++++
 tb/tb_ram_memory_latency.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_latency_pkg.sv
// Shared definitions for the latency-configurable RAM slave: FSM encoding,
// stall LFSR taps and an elaboration-time log2 helper.
package ram_latency_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ram_memory_latency_lfsr_stall_gen.sv
// 16-bit Fibonacci LFSR that steps once per accepted transaction; its two
// low bits seed the extra wait cycles of the RAM slave.
module lfsr_stall_gen
   import ram_latency_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       advance,
   output logic [1:0] lfsr_low
);

   logic [15:0] lfsr;
   logic        feedback;

   assign feedback = ^(lfsr & LFSR_TAPS);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lfsr <= SEED;
      end else if (advance) begin
         lfsr <= {lfsr[14:0], feedback};
      end
   end

   assign lfsr_low = lfsr[1:0];

endmodule

// File: rtl/ram_memory_latency.sv
// RAM slave for the rvsteel_core IO interface with programmable read/write
// latency, optional LFSR stall injection and an out-of-range error flag.
//
// state | meaning
// IDLE  | no transaction held, ready to accept
// WAIT  | transaction captured, latency down-counter running, busy=1
// RESP  | one-cycle response pulse; may accept the next request
module ram_memory_latency
   import ram_latency_pkg::*;
#(
   parameter int          MEMORY_SIZE   = 8192,
   parameter int          DATA_WIDTH    = 32,
   parameter int          READ_LATENCY  = 1,
   parameter int          WRITE_LATENCY = 1,
   parameter bit          STALL_ENABLE  = 1'b0,
   parameter int          MAX_STALL     = 3,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [31:0]             rw_address,
   output logic [DATA_WIDTH-1:0]   read_data,
   input  logic                    read_request,
   output logic                    read_response,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strobe,
   input  logic                    write_request,
   output logic                    write_response,
   output logic                    access_error,
   output logic                    busy
);

   localparam int BYTES      = DATA_WIDTH / 8;
   localparam int BYTE_SHIFT = clog2(BYTES);
   localparam int WORDS      = MEMORY_SIZE / BYTES;
   localparam int IDX_W      = clog2(WORDS);

   localparam logic [4:0] RD_LOAD   = 5'(READ_LATENCY - 1);
   localparam logic [4:0] WR_LOAD   = 5'(WRITE_LATENCY - 1);
   localparam logic [1:0] STALL_CAP = (MAX_STALL >= 3) ? 2'd3 : 2'(MAX_STALL);

   state_t               state, state_nxt;
   logic [4:0]           cnt, cnt_nxt, cnt_load;
   logic                 cap_write, cap_err;
   logic [IDX_W-1:0]     cap_idx;
   logic [DATA_WIDTH-1:0] cap_data;
   logic [BYTES-1:0]     cap_strobe;

   logic                 accept, req_err;
   logic [IDX_W-1:0]     req_idx;
   logic [1:0]           lfsr_low, stall;

   logic                 commit_en;
   logic [IDX_W-1:0]     commit_idx;
   logic [DATA_WIDTH-1:0] commit_data;
   logic [BYTES-1:0]     commit_strobe;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   // WAIT ignores requests; write wins when both are raised together
   assign accept  = (state == ST_IDLE || state == ST_RESP) && (read_request || write_request);
   assign req_err = (rw_address >= 32'(MEMORY_SIZE));
   assign req_idx = IDX_W'(rw_address >> BYTE_SHIFT);

   lfsr_stall_gen #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clock    (clock),
      .reset_n  (reset_n),
      .advance  (accept),
      .lfsr_low (lfsr_low)
   );

   assign stall    = STALL_ENABLE ? ((lfsr_low > STALL_CAP) ? STALL_CAP : lfsr_low) : 2'd0;
   assign cnt_load = (write_request ? WR_LOAD : RD_LOAD) + {3'b000, stall};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_WAIT: begin
            cnt_nxt = cnt - 5'd1;
            if (cnt == 5'd1) state_nxt = ST_RESP;
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (accept) begin
         cnt_nxt   = cnt_load;
         state_nxt = (cnt_load == 5'd0) ? ST_RESP : ST_WAIT;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= 5'd0;
         cap_write  <= 1'b0;
         cap_err    <= 1'b0;
         cap_idx    <= '0;
         cap_data   <= '0;
         cap_strobe <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            cap_write  <= write_request;
            cap_err    <= req_err;
            cap_idx    <= req_idx;
            cap_data   <= write_data;
            cap_strobe <= write_strobe;
         end
      end
   end

   // Commit on the edge that enters RESP, either straight from accept or from WAIT
   always_comb begin
      commit_en     = 1'b0;
      commit_idx    = cap_idx;
      commit_data   = cap_data;
      commit_strobe = cap_strobe;
      if (accept && cnt_load == 5'd0) begin
         commit_en     = write_request && !req_err;
         commit_idx    = req_idx;
         commit_data   = write_data;
         commit_strobe = write_strobe;
      end else if (state == ST_WAIT && cnt == 5'd1) begin
         commit_en = cap_write && !cap_err;
      end
      commit_en = commit_en && reset_n;
   end

   always_ff @(posedge clock) begin
      if (commit_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (commit_strobe[b]) mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
         end
      end
   end

   assign busy           = (state == ST_WAIT);
   assign read_response  = (state == ST_RESP) && !cap_write;
   assign write_response = (state == ST_RESP) && cap_write;
   assign access_error   = (state == ST_RESP) && cap_err;
   assign read_data      = (read_response && !cap_err) ? mem[cap_idx] : '0;

endmodule

// File: tb/tb_ram_memory_latency.sv
// Directed plus randomized bench for ram_memory_latency across three latency /
// stall configurations, checked against a behavioural memory and LFSR model.
module tb_ram_memory_latency;

   logic        clock;
   logic        reset_n;
   logic [31:0] addr   [3];
   logic [31:0] wdata  [3];
   logic [3:0]  strb   [3];
   logic        rreq   [3];
   logic        wreq   [3];
   logic [31:0] rdata  [3];
   logic        rresp  [3];
   logic        wresp  [3];
   logic        aerr   [3];
   logic        busy   [3];

   logic [31:0] mem_m  [3][64];
   logic [15:0] lfsr_m [3];
   int          n_cmp;
   int          n_bad;
   logic [31:0] obs;

   ram_memory_latency #(.MEMORY_SIZE(256), .DATA_WIDTH(32), .READ_LATENCY(1), .WRITE_LATENCY(1),
      .STALL_ENABLE(1'b0), .MAX_STALL(3), .LFSR_SEED(16'hACE1)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .rw_address(addr[0]), .read_data(rdata[0]),
      .read_request(rreq[0]), .read_response(rresp[0]), .write_data(wdata[0]),
      .write_strobe(strb[0]), .write_request(wreq[0]), .write_response(wresp[0]),
      .access_error(aerr[0]), .busy(busy[0]));

   ram_memory_latency #(.MEMORY_SIZE(256), .DATA_WIDTH(32), .READ_LATENCY(4), .WRITE_LATENCY(2),
      .STALL_ENABLE(1'b0), .MAX_STALL(3), .LFSR_SEED(16'hACE1)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .rw_address(addr[1]), .read_data(rdata[1]),
      .read_request(rreq[1]), .read_response(rresp[1]), .write_data(wdata[1]),
      .write_strobe(strb[1]), .write_request(wreq[1]), .write_response(wresp[1]),
      .access_error(aerr[1]), .busy(busy[1]));

   ram_memory_latency #(.MEMORY_SIZE(256), .DATA_WIDTH(32), .READ_LATENCY(2), .WRITE_LATENCY(3),
      .STALL_ENABLE(1'b1), .MAX_STALL(2), .LFSR_SEED(16'hACE1)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .rw_address(addr[2]), .read_data(rdata[2]),
      .read_request(rreq[2]), .read_response(rresp[2]), .write_data(wdata[2]),
      .write_strobe(strb[2]), .write_request(wreq[2]), .write_response(wresp[2]),
      .access_error(aerr[2]), .busy(busy[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic int rl(input int i);
      case (i)
         0:       return 1;
         1:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int wl(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int exp_stall(input int i);
      int st;
      if (i != 2) return 0;
      st = int'(lfsr_m[i][1:0]);
      return (st > 2) ? 2 : st;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_quiet(input string tag, input int i);
      check({tag, "_busy"},  busy[i],  1'b0);
      check({tag, "_rresp"}, rresp[i], 1'b0);
      check({tag, "_wresp"}, wresp[i], 1'b0);
      check({tag, "_aerr"},  aerr[i],  1'b0);
      check({tag, "_rdata"}, rdata[i], 32'h0);
   endtask

   // Called #1 after a rising edge; returns #1 after the response edge
   task automatic txn(input int i, input bit wr, input bit rd, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input string tag,
                      output logic [31:0] rd_obs);
      int          exp_lat, lat, busy_n;
      bit          err, leak;
      logic [31:0] exp_rd;
      err     = (a >= 32'd256);
      exp_lat = (wr ? wl(i) : rl(i)) + exp_stall(i);
      lfsr_m[i] = lfsr_step(lfsr_m[i]);
      exp_rd  = (wr || err) ? 32'h0 : mem_m[i][a[7:2]];
      addr[i] = a; wdata[i] = d; strb[i] = s; wreq[i] = wr; rreq[i] = rd;
      @(posedge clock); #1;
      wreq[i] = 1'b0; rreq[i] = 1'b0;
      lat = 1; busy_n = 0; leak = 1'b0;
      while (!(rresp[i] || wresp[i]) && lat < 40) begin
         busy_n += int'(busy[i]);
         leak |= (rdata[i] != 32'h0);
         @(posedge clock); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
      check({tag, "_rdata_idle"}, leak, 1'b0);
      check({tag, "_wresp"}, wresp[i], wr);
      check({tag, "_rresp"}, rresp[i], !wr);
      check({tag, "_aerr"}, aerr[i], err);
      check({tag, "_rdata"}, rdata[i], exp_rd);
      rd_obs = rdata[i];
      if (wr && !err) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[i][a[7:2]][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         addr[i] = '0; wdata[i] = '0; strb[i] = '0; rreq[i] = 1'b0; wreq[i] = 1'b0;
         lfsr_m[i] = 16'hACE1;
      end
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) check_quiet("reset", i);
      reset_n = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 3; i++)
         for (int w = 0; w < 16; w++) txn(i, 1'b1, 1'b0, 32'(w * 4), $urandom, 4'hF, "fill", obs);

      // basic write/read at single-cycle latency
      txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, "t1_wr", obs);
      txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, "t1_rd", obs);
      check("t1_value", obs, 32'hDEADBEEF);

      // long read latency
      txn(1, 1'b1, 1'b0, 32'h0, 32'h12345678, 4'hF, "t2_wr", obs);
      txn(1, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, "t2_rd", obs);
      check("t2_value", obs, 32'h12345678);

      // byte strobes, zero strobe, ignored low address bits
      txn(0, 1'b1, 1'b0, 32'h20, 32'h11111111, 4'hF, "t3_base", obs);
      txn(0, 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, "t3_strb", obs);
      txn(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, "t3_rd", obs);
      check("t3_value", obs, 32'h11BB11DD);
      txn(0, 1'b1, 1'b0, 32'h20, 32'h55555555, 4'h0, "t3_nostrb", obs);
      txn(0, 1'b0, 1'b1, 32'h23, 32'h0, 4'h0, "t3_lowbits", obs);
      check("t3_value2", obs, 32'h11BB11DD);

      // range boundaries; 256 aliases word 0 if the range check is lost
      txn(0, 1'b0, 1'b1, 32'd256, 32'h0, 4'h0, "t4_rd_oor", obs);
      txn(0, 1'b1, 1'b0, 32'd256, 32'hCAFEF00D, 4'hF, "t4_wr_oor", obs);
      txn(0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, "t4_word0", obs);
      txn(0, 1'b1, 1'b0, 32'hFC, 32'h0BADCAFE, 4'hF, "t4_wr_last", obs);
      txn(0, 1'b0, 1'b1, 32'hFF, 32'h0, 4'h0, "t4_rd_last", obs);
      check("t4_last_value", obs, 32'h0BADCAFE);

      // simultaneous requests: write wins
      txn(0, 1'b1, 1'b1, 32'h14, 32'h600DF00D, 4'hF, "simul", obs);
      txn(0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0, "simul_rd", obs);

      // back-to-back writes with the request held high
      addr[0] = 32'h30; wdata[0] = 32'hA5A5A5A5; strb[0] = 4'hF; wreq[0] = 1'b1;
      @(posedge clock); #1;
      check("b2b_first", wresp[0], 1'b1);
      addr[0] = 32'h34; wdata[0] = 32'h5A5A5A5A;
      @(posedge clock); #1;
      wreq[0] = 1'b0;
      check("b2b_second", wresp[0], 1'b1);
      mem_m[0][12] = 32'hA5A5A5A5; mem_m[0][13] = 32'h5A5A5A5A;
      lfsr_m[0] = lfsr_step(lfsr_step(lfsr_m[0]));
      @(posedge clock); #1;
      check("b2b_done", wresp[0], 1'b0);
      txn(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0, "b2b_rd0", obs);
      txn(0, 1'b0, 1'b1, 32'h34, 32'h0, 4'h0, "b2b_rd1", obs);

      // randomized traffic on the long-latency and stalling instances
      for (int n = 0; n < 140; n++) begin
         int          i;
         logic [31:0] a;
         bit          wr;
         i  = (n < 40) ? 1 : 2;
         a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = 32'(256 + $urandom_range(0, 1023));
         wr = 1'($urandom_range(0, 1));
         txn(i, wr, !wr, a, $urandom, 4'($urandom_range(0, 15)), "rand", obs);
      end

      // reset while a write waits in WAIT
      addr[1] = 32'h8; wdata[1] = 32'hFFFF0000; strb[1] = 4'hF; wreq[1] = 1'b1;
      @(posedge clock); #1;
      wreq[1] = 1'b0;
      check("t6_busy_before", busy[1], 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check_quiet("t6_async", 1);
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) lfsr_m[i] = 16'hACE1;
      repeat (3) @(posedge clock);
      #1;
      check_quiet("t6_idle", 1);
      txn(1, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, "t6_unchanged", obs);
      txn(2, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, "t6_seed", obs);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
